moving_interpolator: RTL and testbench



---
 rtl/moving_interpolator_if.sv | 26 ++
 rtl/moving_interpolator.sv | 132 +++++++++++++
 tb/tb_moving_interpolator.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/moving_interpolator_if.sv
// Stream interface for moving_interpolator: sample input handshake, window
// selection and interpolated output handshake grouped on one bundle.
interface moving_interpolator_if #(
  parameter int SIZE_DATA   = 16,
  parameter int SIZE_WINDOW = 7
);
  logic [SIZE_DATA-1:0]   input_data;
  logic                   input_valid;
  logic                   input_ready;
  logic [SIZE_WINDOW-1:0] window_set;
  logic [SIZE_DATA-1:0]   output_data;
  logic                   output_valid;
  logic                   output_ready;

  // Block side.
  modport slave (
    input  input_data, input_valid, window_set, output_ready,
    output input_ready, output_data, output_valid
  );

  // Upstream/downstream driver side.
  modport master (
    output input_data, input_valid, window_set, output_ready,
    input  input_ready, output_data, output_valid
  );
endinterface

// File: rtl/moving_interpolator.sv
// moving_interpolator: linear-interpolating upsampler. One signed sample per
// segment in, N = window_set samples out, walking from the previous sample
// towards the current one as prev + floor(i*diff/N).
// Optional build macro MOVING_INTERPOLATOR_ROUND_EN switches the per-beat
// division from floor to round-half-up.
module moving_interpolator #(
  parameter int SIZE_DATA   = 16,
  parameter int SIZE_WINDOW = 7
) (
  input  logic                 clk,
  input  logic                 reset,   // asynchronous, active low
  moving_interpolator_if.slave bus
);

  localparam int DW = SIZE_DATA + 1;                 // segment slope width
  localparam int PW = SIZE_DATA + SIZE_WINDOW + 1;   // accumulated i*diff
  localparam int KW = (SIZE_WINDOW > 1) ? $clog2(SIZE_WINDOW) : 1;

  typedef enum logic [1:0] {
    S_FIRST = 2'd0,
    S_WAIT  = 2'd1,
    S_EMIT  = 2'd2
  } state_t;

  state_t                        state_q, state_d;
  logic signed [SIZE_DATA-1:0]   prev_q, prev_d;
  logic signed [SIZE_DATA-1:0]   cur_q, cur_d;
  logic signed [DW-1:0]          diff_q, diff_d;
  logic signed [PW-1:0]          p_q, p_d;
  logic [SIZE_WINDOW-1:0]        cnt_q, cnt_d;
  logic [KW-1:0]                 k_seg_q, k_seg_d;

  logic [KW-1:0]                 k_calc;
  logic [SIZE_WINDOW-1:0]        n_last;
  logic signed [PW-1:0]          p_adj;
  logic signed [PW-1:0]          p_shift;
  logic signed [PW-1:0]          sum;
  logic                          emit;

  // Decode window_set to log2; anything that is not a single set bit maps to N = 1.
  always_comb begin
    k_calc = '0;
    for (int i = 0; i < SIZE_WINDOW; i++) begin
      if (bus.window_set == (SIZE_WINDOW'(1) << i)) k_calc = KW'(i);
    end
  end

  // Interpolated output: prev plus the accumulated slope divided by N via shift.
  always_comb begin
    n_last = (SIZE_WINDOW'(1) << k_seg_q) - SIZE_WINDOW'(1);
`ifdef MOVING_INTERPOLATOR_ROUND_EN
    // N>>1 is zero for N = 1, so pass-through needs no special case.
    p_adj  = p_q + PW'((SIZE_WINDOW'(1) << k_seg_q) >> 1);
`else
    p_adj  = p_q;
`endif
    p_shift = p_adj >>> k_seg_q;
    sum     = PW'(prev_q) + p_shift;
  end

  assign emit             = (state_q == S_EMIT);
  assign bus.output_valid = emit;
  // Forced to zero outside EMIT so the bus idles at 0 (including in reset).
  assign bus.output_data  = emit ? sum[SIZE_DATA-1:0] : '0;
  // Held low while reset is asserted even though the FSM sits in FIRST.
  assign bus.input_ready  = reset && (state_q != S_EMIT);

  // Next-state and datapath update for the FIRST/WAIT/EMIT segment machine.
  always_comb begin
    state_d = state_q;
    prev_d  = prev_q;
    cur_d   = cur_q;
    diff_d  = diff_q;
    p_d     = p_q;
    cnt_d   = cnt_q;
    k_seg_d = k_seg_q;
    unique case (state_q)
      S_FIRST: begin
        // First sample only primes prev; nothing to interpolate yet.
        if (bus.input_valid) begin
          prev_d  = $signed(bus.input_data);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.input_valid) begin
          cur_d   = $signed(bus.input_data);
          diff_d  = DW'($signed(bus.input_data)) - DW'(prev_q);
          p_d     = '0;
          cnt_d   = '0;
          k_seg_d = k_calc;   // window is frozen for the whole segment
          state_d = S_EMIT;
        end
      end
      S_EMIT: begin
        if (bus.output_ready) begin
          if (cnt_q == n_last) begin
            // Next segment starts exactly on the sample we were heading for.
            prev_d  = cur_q;
            state_d = S_WAIT;
          end else begin
            p_d   = p_q + PW'(diff_q);
            cnt_d = cnt_q + SIZE_WINDOW'(1);
          end
        end
      end
      default: state_d = S_FIRST;
    endcase
  end

  // State and datapath registers; reset discards any partial segment.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_FIRST;
      prev_q  <= '0;
      cur_q   <= '0;
      diff_q  <= '0;
      p_q     <= '0;
      cnt_q   <= '0;
      k_seg_q <= '0;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      cur_q   <= cur_d;
      diff_q  <= diff_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
      k_seg_q <= k_seg_d;
    end
  end

endmodule

// File: tb/tb_moving_interpolator.sv
// Directed bench for moving_interpolator: ramps, negative slope, full-scale
// segment, backpressure, illegal/changing window and mid-segment reset.
module tb_moving_interpolator;
  localparam int SD = 16;
  localparam int SW = 7;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  moving_interpolator_if #(.SIZE_DATA(SD), .SIZE_WINDOW(SW)) bus();

  moving_interpolator #(.SIZE_DATA(SD), .SIZE_WINDOW(SW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic int od();
    return int'($signed(bus.output_data));
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset            = 1'b0;
    bus.input_valid  = 1'b0;
    bus.output_ready = 1'b1;
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Present a sample at a negedge and hold it until accepted on a posedge.
  task automatic send(input int v);
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    bus.input_data  = SD'(v);
    bus.input_valid = 1'b1;
    for (int c = 0; c < 200; c++) begin
      if (bus.input_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (ok) @(posedge clk);
    #1 bus.input_valid = 1'b0;
    if (!ok) chk("send_timeout", 0, 1);
  endtask

  // Wait for a valid beat (sampled on negedge); output_ready=1 takes it on the next posedge.
  task automatic get_beat(output int d);
    bit ok;
    ok = 1'b0;
    d  = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (bus.output_valid) begin
        ok = 1'b1;
        d  = od();
        break;
      end
    end
    if (!ok) chk("beat_timeout", 0, 1);
  endtask

  task automatic seg(input string tag, input int n, input int first, input int step);
    int d;
    for (int i = 0; i < n; i++) begin
      get_beat(d);
      chk($sformatf("%s[%0d]", tag, i), d, first + i * step);
    end
  endtask

  initial begin
    int d;
    int b[64];
    int viol;
    int exp_neg[4];
    int exp_ext32;

`ifdef MOVING_INTERPOLATOR_ROUND_EN
    exp_neg   = '{0, -1, -1, -2};
    exp_ext32 = 0;         // -32768 + round(32*65535/64) = -32768 + 32768
`else
    exp_neg   = '{0, -1, -2, -3};
    exp_ext32 = -1;        // -32768 + floor(32767.5)
`endif

    bus.input_data   = '0;
    bus.input_valid  = 1'b0;
    bus.output_ready = 1'b1;
    bus.window_set   = 7'd4;

    // Reset state
    #12;
    chk("rst_valid", int'(bus.output_valid), 0);
    chk("rst_in_ready", int'(bus.input_ready), 0);
    chk("rst_data", od(), 0);
    @(negedge clk);
    reset = 1'b1;
    #1 chk("first_in_ready", int'(bus.input_ready), 1);

    // Basic ramp, N=4: 0 -> 8 -> 16
    send(0);
    @(negedge clk);
    chk("first_no_out", int'(bus.output_valid), 0);
    send(8);
    @(negedge clk);
    chk("lat_valid", int'(bus.output_valid), 1);
    chk("emit_in_ready", int'(bus.input_ready), 0);
    chk("ramp[0]", od(), 0);
    seg("ramp", 3, 2, 2);
    send(16);
    seg("ramp2", 4, 8, 2);
    @(negedge clk);
    chk("ramp_done", int'(bus.output_valid), 0);

    // Negative slope, N=4: 0 -> -3
    do_reset();
    send(0);
    send(-3);
    for (int i = 0; i < 4; i++) begin
      get_beat(d);
      chk($sformatf("neg[%0d]", i), d, exp_neg[i]);
    end

    // Full-scale segment, N=64: -32768 -> 32767
    bus.window_set = 7'd64;
    do_reset();
    send(-32768);
    send(32767);
    for (int i = 0; i < 64; i++) get_beat(b[i]);
    viol = 0;
    for (int i = 1; i < 64; i++) if (b[i] < b[i-1]) viol++;
    chk("ext_monotonic_viol", viol, 0);
    chk("ext[0]", b[0], -32768);
    chk("ext[32]", b[32], exp_ext32);
    chk("ext[63]", b[63], 31743);   // -32768 + floor(63*65535/64) = -32768 + 64511

    // Backpressure, N=2: 100 -> 200, output_ready 1,0,0,1
    bus.window_set = 7'd2;
    do_reset();
    send(100);
    send(200);
    @(negedge clk);
    chk("bp_beat0", od(), 100);
    @(negedge clk);
    chk("bp_beat1", od(), 150);
    bus.output_ready = 1'b0;
    @(negedge clk);
    chk("bp_stall1_data", od(), 150);
    chk("bp_stall1_valid", int'(bus.output_valid), 1);
    chk("bp_stall1_in_ready", int'(bus.input_ready), 0);
    @(negedge clk);
    chk("bp_stall2_data", od(), 150);
    chk("bp_stall2_valid", int'(bus.output_valid), 1);
    bus.output_ready = 1'b1;
    @(negedge clk);
    chk("bp_done", int'(bus.output_valid), 0);
    chk("bp_in_ready", int'(bus.input_ready), 1);

    // Illegal window (3) behaves as N=1
    bus.window_set = 7'd3;
    do_reset();
    send(5);
    send(9);
    get_beat(d);
    chk("ill_beat0", d, 5);
    @(negedge clk);
    chk("ill_one_beat", int'(bus.output_valid), 0);
    send(20);
    get_beat(d);
    chk("ill_beat1", d, 9);

    // Window change 4 -> 8 during EMIT takes effect next segment
    bus.window_set = 7'd4;
    do_reset();
    send(0);
    send(40);
    get_beat(d);
    chk("wchg[0]", d, 0);
    bus.window_set = 7'd8;
    seg("wchg_rest", 3, 10, 10);
    @(negedge clk);
    chk("wchg_end", int'(bus.output_valid), 0);
    send(80);
    seg("wnew", 8, 40, 5);
    @(negedge clk);
    chk("wnew_end", int'(bus.output_valid), 0);

    // Reset at beat 2 of an N=8 segment
    bus.window_set = 7'd8;
    do_reset();
    send(0);
    send(80);
    get_beat(d);
    chk("rmid[0]", d, 0);
    get_beat(d);
    chk("rmid[1]", d, 10);
    @(negedge clk);
    chk("rmid[2]", od(), 20);
    reset = 1'b0;
    #1;
    chk("rmid_valid", int'(bus.output_valid), 0);
    chk("rmid_data", od(), 0);
    chk("rmid_in_ready", int'(bus.input_ready), 0);
    @(negedge clk);
    reset = 1'b1;
    #1 chk("rmid_rel_in_ready", int'(bus.input_ready), 1);
    send(7);
    @(negedge clk);
    chk("rmid_first_no_out", int'(bus.output_valid), 0);
    send(15);
    get_beat(d);
    chk("rmid_new[0]", d, 7);
    get_beat(d);
    chk("rmid_new[1]", d, 8);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
